program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// - Boot-time source of the CPU program-memory write port (program_mem_write_en_i, instruction_i, instruction_addr_i).
// - Receives a byte stream over a valid/ready handshake, assembles 16-bit instructions and writes them to
//   consecutive instruction addresses while holding the core in reset; releases the core once loading completes.
// - Sits between the host byte link and the top-level CPU.
// PARAMETERS
// - BASE_ADDR  32'h0  address of the first instruction written
// - ADDR_STEP  2      address increment per instruction (byte-addressed half-words)
// - MAX_INSTR  1024   largest legal instruction count; larger counts go to ERROR
// PORTS
// - clk_i                   in   1   clock
// - reset_i                 in   1   synchronous, active-high reset
// - byte_valid_i            in   1   byte_i carries a valid byte
// - byte_i                  in   8   incoming stream byte
// - byte_ready_o            out  1   loader accepts byte_i this cycle
// - reload_i                in   1   restart loading from RUN or ERROR
// - program_mem_write_en_o  out  1   one-cycle instruction-memory write strobe
// - instruction_o           out  16  instruction being written
// - instruction_addr_o      out  32  write address
// - cpu_reset_o             out  1   held high while loading; drives the core reset
// - load_done_o             out  1   high in RUN
// - load_error_o            out  1   high in ERROR
// BEHAVIOUR
// - Byte transfer occurs on a cycle where byte_valid_i & byte_ready_o are both high; byte_i is ignored otherwise.
// - Stream format (little-endian): count_lo, count_hi, then count x {instr_lo, instr_hi}.
// - FSM: LEN_LO -> LEN_HI -> (count==0 ? RUN : INSTR_LO) -> INSTR_HI -> WRITE -> (remaining>0 ? INSTR_LO : RUN).
// - LEN_HI with count > MAX_INSTR -> ERROR.
// - byte_ready_o is high only in LEN_LO, LEN_HI and INSTR_LO/INSTR_HI; it is low in WRITE, RUN and ERROR.
// - WRITE lasts exactly one cycle: program_mem_write_en_o=1, instruction_o={hi,lo}, instruction_addr_o=current address.
//   The address then advances by ADDR_STEP; 32-bit wrap-around is permitted and unchecked.
// - Latency: the write strobe occurs the cycle after the instr_hi byte is accepted; peak rate is 1 instruction per 3 cycles.
// - instruction_o and instruction_addr_o hold their values outside WRITE; program_mem_write_en_o is 0 outside WRITE.
// - cpu_reset_o=1 in every state except RUN, and it falls on the first RUN cycle.
// - load_done_o=1 only in RUN; load_error_o=1 only in ERROR, and the core stays in reset while in ERROR.
// - reload_i has effect in RUN or ERROR only and is ignored in all other states.
//   When it takes effect: go to LEN_LO, cpu_reset_o=1 next cycle, address returns to BASE_ADDR, counters clear.
// - Reset values: state=LEN_LO, program_mem_write_en_o=0, instruction_o=0, instruction_addr_o=BASE_ADDR,
//   cpu_reset_o=1, byte_ready_o=1, load_done_o=0, load_error_o=0.
// - reset_i mid-load aborts immediately. Words already written are not rescinded; the next load overwrites them.
// - Internal counts are 16 bits wide; the remaining-instruction counter decrements in WRITE.
// CONFIGURATION
// - PROGRAM_LOADER_CHECKSUM_EN defined:
//   - A trailing checksum byte follows the last instruction (or follows count_hi when count==0).
//   - Checksum = XOR of all preceding stream bytes, including the count bytes.
//   - A CHECK state accepts this byte: match -> RUN, mismatch -> ERROR.
//   - Words already written remain in memory after a mismatch.
// - PROGRAM_LOADER_CHECKSUM_EN undefined: there is no CHECK state, and the last WRITE (or count==0) goes directly to RUN.
// TESTING
// - Stream 02 00 34 12 78 56 -> two writes: (addr 0x0, 0x1234) then (addr 0x2, 0x5678).
//   cpu_reset_o falls the cycle after the second write strobe; load_done_o=1.
// - Stream 00 00 -> no write strobe, RUN reached straight from LEN_HI, cpu_reset_o=0.
// - Count 0x0401 with MAX_INSTR=1024 -> ERROR, load_error_o=1, byte_ready_o=0, no writes.
// - Stream 01 00 CD AB with byte_valid_i toggled every other cycle -> exactly one write (0x0, 0xABCD).
//   No byte is lost or duplicated, and ready stays low during the WRITE cycle.
// - reset_i asserted after the first instr_lo byte -> all outputs at reset values next cycle.
//   Then stream 01 00 11 22 -> single write (0x0, 0x2211).
// - With CHECKSUM_EN: stream 01 00 34 12 27 -> RUN (01^00^34^12=27); stream 01 00 34 12 00 -> ERROR.
//   In the ERROR case, reload_i and then a valid stream -> RUN.

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-time loader. Assembles 16-bit instructions from a byte
//               stream and writes them to program memory while holding the
//               core in reset. Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//               (trailing XOR checksum byte, checked in a CHECK state).
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned ADDR_STEP = 2,
    parameter int unsigned MAX_INSTR = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    input  logic        reload_i,
    output logic        program_mem_write_en_o,
    output logic [15:0] instruction_o,
    output logic [31:0] instruction_addr_o,
    output logic        cpu_reset_o,
    output logic        load_done_o,
    output logic        load_error_o
);

    typedef enum logic [2:0] {
        S_LEN_LO   = 3'd0,
        S_LEN_HI   = 3'd1,
        S_INSTR_LO = 3'd2,
        S_INSTR_HI = 3'd3,
        S_WRITE    = 3'd4,
        S_RUN      = 3'd5,
        S_ERROR    = 3'd6,
        S_CHECK    = 3'd7
    } state_t;

    localparam logic [15:0] c_max_instr = 16'(MAX_INSTR);
    localparam logic [31:0] c_addr_step = 32'(ADDR_STEP);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t      c_done_state = S_CHECK;
`else
    localparam state_t      c_done_state = S_RUN;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic        w_ready;
    logic        w_accept;
    logic        w_reload;
    logic [15:0] w_count;
    logic [7:0]  r_count_lo;
    logic [15:0] r_remaining;
    logic [7:0]  r_lo;
    logic [15:0] r_instr;
    logic [31:0] r_next_addr;
    logic [31:0] r_addr_out;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_accept = byte_valid_i & w_ready;
    assign w_reload = reload_i & ((r_state == S_RUN) | (r_state == S_ERROR));
    assign w_count  = {byte_i, r_count_lo};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_LEN_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            S_LEN_LO: begin
                w_ready = 1'b1;
                if (w_accept) w_next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    if (w_count > c_max_instr)   w_next_state = S_ERROR;
                    else if (w_count == 16'd0)   w_next_state = c_done_state;
                    else                         w_next_state = S_INSTR_LO;
                end
            end
            S_INSTR_LO: begin
                w_ready = 1'b1;
                if (w_accept) w_next_state = S_INSTR_HI;
            end
            S_INSTR_HI: begin
                w_ready = 1'b1;
                if (w_accept) w_next_state = S_WRITE;
            end
            // Remaining still counts the instruction being written this cycle.
            S_WRITE: begin
                if (r_remaining == 16'd1) w_next_state = c_done_state;
                else                      w_next_state = S_INSTR_LO;
            end
            S_RUN, S_ERROR: begin
                if (reload_i) w_next_state = S_LEN_LO;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_ready = 1'b1;
                if (w_accept) w_next_state = (byte_i == r_csum) ? S_RUN : S_ERROR;
            end
`endif
            default: w_next_state = S_LEN_LO;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count_lo  <= 8'd0;
            r_remaining <= 16'd0;
            r_lo        <= 8'd0;
            r_instr     <= 16'd0;
            r_next_addr <= BASE_ADDR;
            r_addr_out  <= BASE_ADDR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else if (w_reload) begin
            r_count_lo  <= 8'd0;
            r_remaining <= 16'd0;
            r_next_addr <= BASE_ADDR;
            r_addr_out  <= BASE_ADDR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            if (w_accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                r_csum <= r_csum ^ byte_i;
`endif
                case (r_state)
                    S_LEN_LO:   r_count_lo  <= byte_i;
                    S_LEN_HI:   r_remaining <= w_count;
                    S_INSTR_LO: r_lo        <= byte_i;
                    // Output registers load here so they are valid during WRITE and hold afterwards.
                    S_INSTR_HI: begin
                        r_instr    <= {byte_i, r_lo};
                        r_addr_out <= r_next_addr;
                    end
                    default: ;
                endcase
            end
            if (r_state == S_WRITE) begin
                r_remaining <= r_remaining - 16'd1;
                r_next_addr <= r_next_addr + c_addr_step;
            end
        end
    end

    assign byte_ready_o           = w_ready;
    assign program_mem_write_en_o = (r_state == S_WRITE);
    assign instruction_o          = r_instr;
    assign instruction_addr_o     = r_addr_out;
    assign cpu_reset_o            = (r_state != S_RUN);
    assign load_done_o            = (r_state == S_RUN);
    assign load_error_o           = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Randomised self-checking bench for program_loader with a
//               stream-position reference model and literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam logic [31:0] c_base = 32'h0;
    localparam int          c_step = 2;
    localparam int          c_max  = 1024;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit          c_cs   = 1'b1;
`else
    localparam bit          c_cs   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i, byte_valid_i, reload_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o, program_mem_write_en_o, cpu_reset_o, load_done_o, load_error_o;
    logic [15:0] instruction_o;
    logic [31:0] instruction_addr_o;

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(c_base), .ADDR_STEP(c_step), .MAX_INSTR(c_max)) dut (
        .clk_i(clk), .reset_i(reset_i), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
        .byte_ready_o(byte_ready_o), .reload_i(reload_i),
        .program_mem_write_en_o(program_mem_write_en_o), .instruction_o(instruction_o),
        .instruction_addr_o(instruction_addr_o), .cpu_reset_o(cpu_reset_o),
        .load_done_o(load_done_o), .load_error_o(load_error_o));

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    // Reference model: progress through a load is tracked purely by stream position.
    bit          m_valid = 1'b0;
    int          m_phase;            // 0 loading, 1 run, 2 error
    int          m_n, m_widx, m_pos;
    bit          m_wpend;
    logic [15:0] m_count, m_instr;
    logic [7:0]  m_cnt_lo, m_lo, m_xor;
    logic [31:0] m_addr;

    task automatic model_accept(input logic [7:0] b);
        m_pos = m_n;
        m_n++;
        if (m_pos == 0) begin
            m_cnt_lo = b; m_xor ^= b;
        end else if (m_pos == 1) begin
            m_count = {b, m_cnt_lo}; m_xor ^= b;
            if (int'(m_count) > c_max) m_phase = 2;
            else if (m_count == 0 && !c_cs) m_phase = 1;
        end else if (m_pos < 2 + 2 * int'(m_count)) begin
            m_xor ^= b;
            if (m_pos % 2 == 0) m_lo = b;
            else begin
                m_instr = {b, m_lo};
                m_addr  = c_base + 32'(m_widx * c_step);
                m_wpend = 1'b1;
            end
        end else begin
            m_phase = (b == m_xor) ? 1 : 2;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cycle++;
        if (reset_i) begin
            m_valid = 1'b1; m_phase = 0; m_n = 0; m_widx = 0; m_xor = 8'd0;
            m_wpend = 1'b0; m_instr = 16'd0; m_addr = c_base; m_count = 16'd0;
        end else if (m_valid) begin
            if (m_phase != 0) begin
                if (reload_i) begin
                    m_phase = 0; m_n = 0; m_widx = 0; m_xor = 8'd0; m_wpend = 1'b0; m_addr = c_base;
                end
            end else if (m_wpend) begin
                m_wpend = 1'b0;
                m_widx++;
                if (m_widx == int'(m_count) && !c_cs) m_phase = 1;
            end else if (byte_valid_i) begin
                model_accept(byte_i);
            end
        end
    end

    // Per-cycle compare plus write log for literal checks.
    logic [31:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          last_wr_cycle = 0, done_cycle = 0;
    logic        prev_done = 1'b0;

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("ready",    32'(byte_ready_o),           32'(m_phase == 0 && !m_wpend));
            chk("wr_en",    32'(program_mem_write_en_o), 32'(m_phase == 0 && m_wpend));
            chk("instr",    32'(instruction_o),          32'(m_instr));
            chk("addr",     instruction_addr_o,          m_addr);
            chk("cpu_rst",  32'(cpu_reset_o),            32'(m_phase != 1));
            chk("done",     32'(load_done_o),            32'(m_phase == 1));
            chk("error",    32'(load_error_o),           32'(m_phase == 2));
        end
        if (program_mem_write_en_o === 1'b1) begin
            wr_addr.push_back(instruction_addr_o);
            wr_data.push_back(instruction_o);
            last_wr_cycle = cycle;
        end
        if (load_done_o === 1'b1 && !prev_done) done_cycle = cycle;
        prev_done = (load_done_o === 1'b1);
    end

    logic [7:0] sq[$];

    task automatic add_cs(input bit bad);
        logic [7:0] x;
        x = 8'd0;
        foreach (sq[i]) x ^= sq[i];
        if (c_cs) sq.push_back(bad ? ~x : x);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit rnd_reload);
        int t;
        repeat (gap) begin
            byte_valid_i = 1'b0; byte_i = 8'($urandom);
            reload_i = rnd_reload && ($urandom_range(0, 3) == 0);
            @(negedge clk); #1;
        end
        reload_i = 1'b0;
        byte_valid_i = 1'b1; byte_i = b;
        t = 0;
        while (byte_ready_o !== 1'b1 && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (byte_ready_o !== 1'b1) begin
            tests++; fails++;
            $display("FAIL send_timeout: ready stayed %b, expected 1", byte_ready_o);
        end
        @(negedge clk); #1;
        byte_valid_i = 1'b0; byte_i = 8'($urandom);
    endtask

    task automatic send_stream(input int first, input int last, input int maxgap);
        for (int i = first; i < last && i < sq.size(); i++)
            send_byte(sq[i], (maxgap < 0) ? 1 : $urandom_range(0, maxgap), maxgap > 0);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(load_done_o === 1'b1 || load_error_o === 1'b1) && t < 5000) begin
            @(negedge clk); #1; t++;
        end
        if (!(load_done_o === 1'b1 || load_error_o === 1'b1)) begin
            tests++; fails++;
            $display("FAIL wait_end: done=%b error=%b, expected one high", load_done_o, load_error_o);
        end
    endtask

    task automatic do_reload();
        reload_i = 1'b1; @(negedge clk); #1; reload_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1; @(negedge clk); #1; reset_i = 1'b0;
    endtask

    task automatic new_test();
        wr_addr.delete(); wr_data.delete(); sq.delete();
    endtask

    initial begin
        int cnt, r;
        reset_i = 1'b1; byte_valid_i = 1'b0; reload_i = 1'b0; byte_i = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready",   32'(byte_ready_o), 32'd1);
        chk("rst_cpu_rst", 32'(cpu_reset_o),  32'd1);
        chk("rst_addr",    instruction_addr_o, 32'h0);
        chk("rst_instr",   32'(instruction_o), 32'h0);
        reset_i = 1'b0;

        // Two-instruction load
        new_test();
        sq = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        add_cs(1'b0);
        send_stream(0, sq.size(), 0);
        wait_end();
        chk("t1_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t1_a0", wr_addr[0], 32'h0); chk("t1_d0", 32'(wr_data[0]), 32'h1234);
            chk("t1_a1", wr_addr[1], 32'h2); chk("t1_d1", 32'(wr_data[1]), 32'h5678);
        end
        chk("t1_done", 32'(load_done_o), 32'd1);
        chk("t1_rst_fall", 32'(done_cycle - last_wr_cycle), c_cs ? 32'd2 : 32'd1);

        // Empty program
        do_reload(); new_test();
        sq = '{8'h00, 8'h00};
        add_cs(1'b0);
        send_stream(0, sq.size(), 0);
        wait_end();
        chk("t2_nwr", 32'(wr_addr.size()), 32'd0);
        chk("t2_cpu_rst", 32'(cpu_reset_o), 32'd0);

        // Oversized count
        do_reload(); new_test();
        sq = '{8'h01, 8'h04};
        send_stream(0, 2, 0);
        wait_end();
        chk("t3_err", 32'(load_error_o), 32'd1);
        chk("t3_ready", 32'(byte_ready_o), 32'd0);
        chk("t3_nwr", 32'(wr_addr.size()), 32'd0);

        // Throttled valid
        do_reload(); new_test();
        sq = '{8'h01, 8'h00, 8'hCD, 8'hAB};
        add_cs(1'b0);
        send_stream(0, sq.size(), -1);
        wait_end();
        chk("t4_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t4_a0", wr_addr[0], 32'h0); chk("t4_d0", 32'(wr_data[0]), 32'hABCD);
        end

        // Reset mid-load, then reload
        do_reload(); new_test();
        sq = '{8'h01, 8'h00, 8'h11};
        send_stream(0, 3, 0);
        do_reset();
        chk("t5_ready", 32'(byte_ready_o), 32'd1);
        chk("t5_wr_en", 32'(program_mem_write_en_o), 32'd0);
        chk("t5_cpu_rst", 32'(cpu_reset_o), 32'd1);
        chk("t5_done", 32'(load_done_o), 32'd0);
        new_test();
        sq = '{8'h01, 8'h00, 8'h11, 8'h22};
        add_cs(1'b0);
        send_stream(0, sq.size(), 0);
        wait_end();
        chk("t5_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t5_a0", wr_addr[0], 32'h0); chk("t5_d0", 32'(wr_data[0]), 32'h2211);
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        do_reload(); new_test();
        sq = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h27};
        send_stream(0, sq.size(), 0);
        wait_end();
        chk("cs_ok_done", 32'(load_done_o), 32'd1);
        do_reload(); new_test();
        sq = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h00};
        send_stream(0, sq.size(), 0);
        wait_end();
        chk("cs_bad_err", 32'(load_error_o), 32'd1);
        chk("cs_bad_nwr", 32'(wr_addr.size()), 32'd1);
        do_reload(); new_test();
        sq = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h27};
        send_stream(0, sq.size(), 0);
        wait_end();
        chk("cs_recover", 32'(load_done_o), 32'd1);
`endif

        // Randomised loads checked by the model every cycle
        for (int it = 0; it < 40; it++) begin
            do_reload(); new_test();
            r = $urandom_range(0, 9);
            cnt = (r == 9) ? 1025 + $urandom_range(0, 500) : $urandom_range(0, 6);
            sq.push_back(8'(cnt)); sq.push_back(8'(cnt >> 8));
            if (cnt <= c_max) begin
                for (int k = 0; k < 2 * cnt; k++) sq.push_back(8'($urandom));
                add_cs($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 7) == 0) begin
                send_stream(0, $urandom_range(1, sq.size()), 2);
                do_reset();
            end else begin
                send_stream(0, sq.size(), 2);
                wait_end();
                repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
